// File: rtl/gate_scheduler_pkg.sv
// Shared types and defaults for the gate_scheduler photon-counting window sequencer.
package gate_scheduler_pkg;

  localparam int IDX_W      = 16;

  localparam int DEF_NCH    = 2;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WIN_W  = 32;
  localparam int DEF_SETTLE = 16;
  localparam int DEF_DRAIN  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_DRAIN,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         ovf
);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) ovf   <= 1'b1;
      else        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gate_scheduler.sv
// Per-pattern integration window sequencer: settle, gate, drain, then report counts.
// Optional coincidence counter enabled by defining GATE_SCHEDULER_COINC_EN.
module gate_scheduler
  import gate_scheduler_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int DRAIN  = DEF_DRAIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIN_W-1:0]     cfg_window,
  input  logic [NCH-1:0]       pulse_in,
  output logic [NCH-1:0]       shaper_en,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NCH*CNT_W-1:0] res_count,
  output logic [NCH-1:0]       res_overflow,
  output logic [IDX_W-1:0]     res_index,
  output logic                 err_overrun
`ifdef GATE_SCHEDULER_COINC_EN
  ,
  output logic [CNT_W-1:0]     res_coinc
`endif
);

  state_t            state, next_state;
  logic [WIN_W-1:0]  timer;
  logic [WIN_W-1:0]  win_q;
  logic              busy_d, valid_d;
  logic [NCH-1:0]    shaper_d;

  wire accept     = (state == ST_IDLE) && start && !abort;
  wire timer_zero = (timer == '0);
  wire counting   = (state == ST_GATE) || (state == ST_DRAIN);
  wire handshake  = (state == ST_REPORT) && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      shaper_en <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= busy_d;
      shaper_en <= shaper_d;
      res_valid <= valid_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start && !abort)  next_state = ST_SETTLE;
      ST_SETTLE: if (abort)            next_state = ST_IDLE;
                 else if (timer_zero)  next_state = ST_GATE;
      ST_GATE:   if (abort)            next_state = ST_IDLE;
                 else if (timer_zero)  next_state = ST_DRAIN;
      ST_DRAIN:  if (abort)            next_state = ST_IDLE;
                 else if (timer_zero)  next_state = ST_REPORT;
      ST_REPORT: if (res_ready || abort) next_state = ST_IDLE;
      default:                         next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state register.
  always_comb begin
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    shaper_d = '0;
    case (next_state)
      ST_SETTLE, ST_GATE: begin
        busy_d   = 1'b1;
        shaper_d = '1;
      end
      ST_DRAIN:  busy_d = 1'b1;
      ST_REPORT: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase timer reloads with (length-1) on every state entry; the phase ends when it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      win_q       <= WIN_W'(1);
      res_index   <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (accept)
        win_q <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;

      if (next_state != state) begin
        case (next_state)
          ST_SETTLE: timer <= WIN_W'(SETTLE - 1);
          ST_GATE:   timer <= win_q - 1'b1;
          ST_DRAIN:  timer <= WIN_W'(DRAIN - 1);
          default:   timer <= '0;
        endcase
      end else if (!timer_zero) begin
        timer <= timer - 1'b1;
      end

      if (handshake)
        res_index <= res_index + 1'b1;

      if (start && (state != ST_IDLE))
        err_overrun <= 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .inc   (counting && pulse_in[i]),
      .count (res_count[i*CNT_W +: CNT_W]),
      .ovf   (res_overflow[i])
    );
  end

`ifdef GATE_SCHEDULER_COINC_EN
  logic coinc_ovf_unused;

  sat_counter #(.W(CNT_W)) u_coinc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (counting && (&pulse_in)),
    .count (res_coinc),
    .ovf   (coinc_ovf_unused)
  );
`endif

endmodule

// File: tb/tb_gate_scheduler.sv
// Randomized self-checking bench for gate_scheduler; two instances (16-bit and 4-bit counts) share stimulus.
module tb_gate_scheduler;

  localparam int SET = 16;
  localparam int DRN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] cfg_window;
  logic [1:0]  pulse_in;
  logic        res_ready;

  logic [1:0]  shaper_en, shaper_en4;
  logic        busy, busy4;
  logic        res_valid, res_valid4;
  logic [31:0] res_count;
  logic [7:0]  res_count4;
  logic [1:0]  res_overflow, res_overflow4;
  logic [15:0] res_index, res_index4;
  logic        err_overrun, err_overrun4;
`ifdef GATE_SCHEDULER_COINC_EN
  logic [15:0] res_coinc;
  logic [3:0]  res_coinc4;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_index = '0;
  bit          exp_overrun = 1'b0;
  int          pmode = 0;
  int          pprob = 50;

  gate_scheduler #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_window(cfg_window),
    .pulse_in(pulse_in), .shaper_en(shaper_en), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_overflow(res_overflow),
    .res_index(res_index), .err_overrun(err_overrun)
`ifdef GATE_SCHEDULER_COINC_EN
    , .res_coinc(res_coinc)
`endif
  );

  gate_scheduler #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_window(cfg_window),
    .pulse_in(pulse_in), .shaper_en(shaper_en4), .busy(busy4), .res_valid(res_valid4),
    .res_ready(res_ready), .res_count(res_count4), .res_overflow(res_overflow4),
    .res_index(res_index4), .err_overrun(err_overrun4)
`ifdef GATE_SCHEDULER_COINC_EN
    , .res_coinc(res_coinc4)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sat(int v, int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Pulse pattern for the cycle whose inputs are sampled at edge k after the start edge.
  function automatic logic [1:0] pick_pulse(int k);
    int j = k - (SET + 1);
    case (pmode)
      1: return {k % 7 == 0, k % 5 == 0};
      2: begin
        if (j >= 0 && j < 20 && j % 2 == 0)
          return (j / 2 < 7) ? 2'b11 : ((j / 2 < 10) ? 2'b01 : 2'b00);
        return 2'b00;
      end
      3: return (j >= 0 && j < 20) ? 2'b11 : 2'b00;
      default: return {$urandom_range(99) < pprob, $urandom_range(99) < pprob};
    endcase
  endfunction

  // Runs one window starting at the current negedge; ends positioned at a negedge.
  task automatic run_window(input string name, input int win, input int abort_k,
                            input int overrun_k, input int ready_delay, input bit hs_abort);
    int w, last;
    int r0, r1, rc;
    bit saw;
    logic [1:0]  p;
    logic [31:0] e16;
    logic [7:0]  e4;
    logic [1:0]  eo16, eo4;
    w    = (win == 0) ? 1 : win;
    last = SET + w + DRN;
    r0 = 0; r1 = 0; rc = 0;
    start      = 1'b1;
    cfg_window = 32'(win);
    pulse_in   = pick_pulse(0);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cfg_window = $urandom;
      if (k == 1) begin
        checks++;
        if ({busy, busy4, shaper_en, shaper_en4, res_count, res_count4, res_overflow, res_overflow4} !==
            {2'b11, 4'b1111, 32'h0, 8'h0, 4'h0})
          begin errors++; $display("FAIL %s start: busy/shaper/count got %b %b %h %h %b %b", name,
                 busy, shaper_en, res_count, res_count4, res_overflow, res_overflow4); end
      end
      if (abort_k != 0 && k == abort_k + 1) begin
        checks++;
        if ({busy, busy4, shaper_en, shaper_en4} !== 6'b0)
          begin errors++; $display("FAIL %s abort: busy=%b shaper_en=%b expected 0", name, busy, shaper_en); end
        saw = 1'b0;
        repeat (last) begin
          pulse_in = 2'($urandom);
          @(negedge clk);
          if (res_valid || res_valid4) saw = 1'b1;
        end
        pulse_in = 2'b00;
        checks++;
        if (saw !== 1'b0)
          begin errors++; $display("FAIL %s abort: res_valid seen=%b expected 0", name, saw); end
        return;
      end
      if (k == SET + w) begin
        checks++;
        if ({shaper_en, shaper_en4} !== 4'b1111)
          begin errors++; $display("FAIL %s last_gate: shaper_en=%b expected 11", name, shaper_en); end
      end
      if (k == SET + w + 1) begin
        checks++;
        if ({shaper_en, shaper_en4, busy} !== 5'b00001)
          begin errors++; $display("FAIL %s drain: shaper_en=%b busy=%b expected 00 1", name, shaper_en, busy); end
      end
      if (k == last) begin
        checks++;
        if ({res_valid, res_valid4} !== 2'b00)
          begin errors++; $display("FAIL %s early_valid: cycle %0d res_valid=%b expected 0", name, k, res_valid); end
      end
      if (k == last + 1) begin
        checks++;
        if ({res_valid, res_valid4} !== 2'b11)
          begin errors++; $display("FAIL %s latency: cycle %0d res_valid=%b expected 1", name, k, res_valid); end
      end
      if (k <= last) begin
        p = pick_pulse(k);
        pulse_in = p;
        if (k > SET) begin
          r0 += int'(p[0]);
          r1 += int'(p[1]);
          rc += int'(&p);
        end
        if (k == overrun_k) begin start = 1'b1; exp_overrun = 1'b1; end
        if (k == abort_k) abort = 1'b1;
      end
    end

    e16  = {16'(sat(r1, 16)), 16'(sat(r0, 16))};
    eo16 = {r1 > 65535, r0 > 65535};
    e4   = {4'(sat(r1, 4)), 4'(sat(r0, 4))};
    eo4  = {r1 > 15, r0 > 15};
    checks++;
    if ({res_count, res_overflow, res_index, err_overrun} !== {e16, eo16, exp_index, exp_overrun})
      begin errors++; $display("FAIL %s result16: got %h %b %h %b expected %h %b %h %b", name,
             res_count, res_overflow, res_index, err_overrun, e16, eo16, exp_index, exp_overrun); end
    checks++;
    if ({res_count4, res_overflow4, res_index4, err_overrun4} !== {e4, eo4, exp_index, exp_overrun})
      begin errors++; $display("FAIL %s result4: got %h %b %h %b expected %h %b %h %b", name,
             res_count4, res_overflow4, res_index4, err_overrun4, e4, eo4, exp_index, exp_overrun); end
`ifdef GATE_SCHEDULER_COINC_EN
    checks++;
    if ({res_coinc, res_coinc4} !== {16'(sat(rc, 16)), 4'(sat(rc, 4))})
      begin errors++; $display("FAIL %s coinc: got %0d/%0d expected %0d", name, res_coinc, res_coinc4, rc); end
`endif

    repeat (ready_delay) begin
      pulse_in = 2'($urandom);
      @(negedge clk);
      checks++;
      if ({res_valid, res_count, res_overflow, res_index, res_valid4, res_count4, res_overflow4} !==
          {1'b1, e16, eo16, exp_index, 1'b1, e4, eo4})
        begin errors++; $display("FAIL %s hold: got %b %h %b %h expected 1 %h %b %h", name,
               res_valid, res_count, res_overflow, res_index, e16, eo16, exp_index); end
    end

    pulse_in  = 2'($urandom);
    res_ready = 1'b1;
    abort     = hs_abort;
    @(negedge clk);
    res_ready = 1'b0;
    abort     = 1'b0;
    pulse_in  = 2'b00;
    exp_index = exp_index + 16'd1;
    checks++;
    if ({res_valid, busy, res_index, res_valid4, busy4, res_index4} !== {2'b00, exp_index, 2'b00, exp_index})
      begin errors++; $display("FAIL %s handshake: valid=%b busy=%b index=%h expected 0 0 %h", name,
             res_valid, busy, res_index, exp_index); end
  endtask

  task automatic test_reset();
    checks++;
    if ({shaper_en, busy, res_valid, res_count, res_overflow, res_index, err_overrun,
         shaper_en4, busy4, res_valid4, res_count4, res_overflow4, res_index4, err_overrun4} !== '0)
      begin errors++; $display("FAIL reset: shaper=%b busy=%b valid=%b count=%h ovf=%b idx=%h ovr=%b expected all 0",
             shaper_en, busy, res_valid, res_count, res_overflow, res_index, err_overrun); end
  endtask

  task automatic test_basic();
    pmode = 1;
    run_window("basic", 100, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    pmode = 0;
    run_window("win_zero", 0, 0, 0, 1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      pprob = int'($urandom_range(80, 10));
      run_window("random", int'($urandom_range(40, 1)), 0, 0, int'($urandom_range(3)), 1'b0);
    end
  endtask

  task automatic test_overflow();
    pmode = 3;
    run_window("overflow", 30, 0, 0, 0, 1'b0);
    pmode = 0; pprob = 5;
    run_window("after_overflow", 5, 0, 0, 0, 1'b0);
  endtask

  task automatic test_coinc();
    pmode = 2;
    run_window("coinc", 30, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    pmode = 0; pprob = 50;
    run_window("abort_gate", 50, SET + 10, 0, 0, 1'b0);
    run_window("abort_settle", 20, 3, 0, 0, 1'b0);
    run_window("after_abort", 12, 0, 0, 0, 1'b0);
  endtask

  task automatic test_idle_abort();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, busy4, err_overrun} !== {2'b00, exp_overrun})
      begin errors++; $display("FAIL idle_abort: busy=%b err_overrun=%b expected 0 %b", busy, err_overrun, exp_overrun); end
  endtask

  task automatic test_ready_hold();
    pmode = 0; pprob = 40;
    run_window("ready_hold", 20, 0, 0, 50, 1'b0);
  endtask

  task automatic test_back_to_back();
    pmode = 0; pprob = 60;
    run_window("b2b_first", 6, 0, 0, 0, 1'b0);
    run_window("b2b_second", 9, 0, 0, 0, 1'b0);
    run_window("report_abort", 10, 0, 0, 2, 1'b1);
  endtask

  task automatic test_overrun();
    pmode = 0; pprob = 30;
    run_window("overrun", 40, 0, SET + 5, 0, 1'b0);
    run_window("overrun_sticky", 8, 0, 0, 0, 1'b0);
  endtask

  task automatic test_rst_mid();
    pmode = 0; pprob = 70;
    start = 1'b1; cfg_window = 32'd60;
    @(negedge clk);
    start = 1'b0;
    repeat (30) begin pulse_in = 2'($urandom); @(negedge clk); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({shaper_en, busy, res_valid, res_count, res_overflow, res_index, err_overrun,
         busy4, res_count4, res_index4, err_overrun4} !== '0)
      begin errors++; $display("FAIL rst_mid: busy=%b shaper=%b count=%h idx=%h ovr=%b expected all 0",
             busy, shaper_en, res_count, res_index, err_overrun); end
    @(negedge clk);
    rst = 1'b0;
    pulse_in = 2'b00;
    exp_index = '0;
    exp_overrun = 1'b0;
    run_window("after_rst", 8, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_window = '0; pulse_in = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_overflow();
    test_coinc();
    test_abort();
    test_idle_abort();
    test_ready_hold();
    test_back_to_back();
    test_overrun();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
